// File: rtl/dilithium_pkg.sv
// Shared ML-DSA definitions: modulus, controller states, parameter-set
// selection and the mode -> {K, L, eta} lookup.
package dilithium_pkg;

   localparam int unsigned Q = 32'd8380417;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLR     = 3'd1,
      ST_ABSORB  = 3'd2,
      ST_SQUEEZE = 3'd3,
      ST_FIN     = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      MODE_44   = 2'd0,
      MODE_65   = 2'd1,
      MODE_87   = 2'd2,
      MODE_RSVD = 2'd3
   } mode_t;

   typedef struct packed {
      logic [3:0] k;
      logic [3:0] l;
      logic       eta4;
   } mode_cfg_t;

   // The reserved encoding falls back to the smallest parameter set.
   function automatic mode_cfg_t mode_cfg(input mode_t m);
      mode_cfg_t c;
      case (m)
         MODE_65: c = '{k: 4'd6, l: 4'd5, eta4: 1'b1};
         MODE_87: c = '{k: 4'd8, l: 4'd7, eta4: 1'b0};
         default: c = '{k: 4'd4, l: 4'd4, eta4: 1'b0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/eta_nibble_decode.sv
// Rejection test and CoeffFromHalfByte for one nibble. The coefficient is
// returned already reduced into [0, q): negative values map to q + v.
module eta_nibble_decode
   import dilithium_pkg::*;
#(
   parameter int CW = 24
) (
   input  logic [3:0]    b,
   input  logic          eta4,
   output logic          accept,
   output logic [CW-1:0] coeff
);

   logic [3:0] m;
   logic [3:0] bound;

   // eta=2 keeps b<15 and maps to 2-(b mod 5); eta=4 keeps b<9 and maps to 4-b.
   always_comb begin
      accept = eta4 ? (b < 4'd9) : (b < 4'd15);
      m      = eta4 ? b : 4'(b % 4'd5);
      bound  = eta4 ? 4'd4 : 4'd2;
      coeff  = '0;
      if (m <= bound) coeff = CW'(bound - m);
      else            coeff = CW'(Q) - CW'(m - bound);
   end

endmodule

// File: rtl/expand_s_stream.sv
// ML-DSA ExpandS: for each polynomial r, absorb rho' || r (16-bit LE) into the
// external SHAKE256, then stream squeeze words through a nibble shift register,
// reject/decode each nibble and pack accepted coefficients into NTT RAM words.
// s1 polynomials come first, then s2, contiguous from S_BASE.
//
// Handshakes: an absorb word moves on sh_in_valid && sh_in_ready and
// data/valid/last stay stable until it does; a squeeze word moves on
// sh_out_valid && sh_out_ready, and ready is raised only when the nibble
// buffer is empty, so either side may stall for any number of cycles.
module expand_s_stream
   import dilithium_pkg::*;
#(
   parameter int WORD_WIDTH     = 64,
   parameter int RAW_ADDR_WIDTH = 12,
   parameter int RHO_BASE       = 0,
   parameter int COEFF_WIDTH    = 24,
   parameter int COEFF_PER_WORD = 4,
   parameter int NTT_ADDR_WIDTH = 12,
   parameter int S_BASE         = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [1:0]                            mode,
   output logic                                  busy,
   output logic                                  done,
   output logic [RAW_ADDR_WIDTH-1:0]             rho_addr,
   input  logic [WORD_WIDTH-1:0]                 rho_data,
   output logic                                  sh_rst,
   output logic [WORD_WIDTH-1:0]                 sh_in_data,
   output logic                                  sh_in_valid,
   output logic                                  sh_in_last,
   output logic [$clog2(WORD_WIDTH):0]           sh_in_last_len,
   input  logic                                  sh_in_ready,
   input  logic [WORD_WIDTH-1:0]                 sh_out_data,
   input  logic                                  sh_out_valid,
   output logic                                  sh_out_ready,
   output logic                                  s_we,
   output logic [NTT_ADDR_WIDTH-1:0]             s_addr,
   output logic [COEFF_WIDTH*COEFF_PER_WORD-1:0] s_din
);

   localparam int RHO_WORDS      = 512 / WORD_WIDTH;
   localparam int NIBS           = WORD_WIDTH / 4;
   localparam int NIB_CW         = $clog2(NIBS + 1);
   localparam int ABS_CW         = $clog2(RHO_WORDS + 1);
   localparam int WORDS_PER_POLY = 256 / COEFF_PER_WORD;
   localparam int SLOT_W         = $clog2(COEFF_PER_WORD);
   localparam int LEN_W          = $clog2(WORD_WIDTH) + 1;

   state_t                                      state, state_next;
   mode_cfg_t                                   cfg;
   logic [3:0]                                  kl_q;
   logic                                        eta4_q;
   logic [3:0]                                  poly_idx;
   logic [ABS_CW-1:0]                           abs_cnt;
   logic [WORD_WIDTH-1:0]                       nib_buf;
   logic [NIB_CW-1:0]                           nib_cnt;
   logic [7:0]                                  coeff_cnt;
   logic [COEFF_PER_WORD-1:0][COEFF_WIDTH-1:0]  pack, pack_next;
   logic [SLOT_W-1:0]                           slot;
   logic                                        accept;
   logic [COEFF_WIDTH-1:0]                      dec_coeff;
   logic                                        in_fire, out_fire, consume, last_coeff, go;

   assign cfg        = mode_cfg(mode_t'(mode));
   assign go         = (state == ST_IDLE) && start && !done;
   assign in_fire    = (state == ST_ABSORB) && sh_in_ready;
   assign out_fire   = sh_out_valid && sh_out_ready;
   assign consume    = (state == ST_SQUEEZE) && (nib_cnt != '0);
   assign slot       = coeff_cnt[SLOT_W-1:0];
   assign last_coeff = consume && accept && (coeff_cnt == 8'd255);

   assign busy           = (state != ST_IDLE);
   assign sh_rst         = (state == ST_CLR);
   assign sh_in_valid    = (state == ST_ABSORB);
   assign sh_in_last     = sh_in_valid && (abs_cnt == ABS_CW'(RHO_WORDS));
   assign sh_in_last_len = sh_in_last ? LEN_W'(16) : '0;
   assign sh_out_ready   = (state == ST_SQUEEZE) && (nib_cnt == '0);

   eta_nibble_decode #(.CW(COEFF_WIDTH)) u_dec (
      .b      (nib_buf[3:0]),
      .eta4   (eta4_q),
      .accept (accept),
      .coeff  (dec_coeff)
   );

   // Absorb mux and look-ahead read address: the address steps as soon as a
   // word transfers, so the next rho' word is on rho_data one cycle later.
   always_comb begin
      sh_in_data = '0;
      if (sh_in_valid) sh_in_data = sh_in_last ? WORD_WIDTH'(poly_idx) : rho_data;
      rho_addr = '0;
      if (state == ST_CLR)
         rho_addr = RAW_ADDR_WIDTH'(RHO_BASE);
      else if (state == ST_ABSORB)
         rho_addr = RAW_ADDR_WIDTH'(RHO_BASE) + RAW_ADDR_WIDTH'(abs_cnt)
                  + RAW_ADDR_WIDTH'(in_fire);
      pack_next       = pack;
      pack_next[slot] = dec_coeff;
   end

   // Next-state logic for the per-polynomial sequence.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (go) state_next = ST_CLR;
         ST_CLR:     state_next = ST_ABSORB;
         ST_ABSORB:  if (in_fire && sh_in_last) state_next = ST_SQUEEZE;
         ST_SQUEEZE: if (last_coeff)
                        state_next = ((poly_idx + 4'd1) == kl_q) ? ST_FIN : ST_CLR;
         ST_FIN:     state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Datapath: mode latch, absorb counter, nibble buffer, packing and RAM write.
   always_ff @(posedge clk) begin
      if (rst) begin
         kl_q      <= '0;
         eta4_q    <= 1'b0;
         poly_idx  <= '0;
         abs_cnt   <= '0;
         nib_buf   <= '0;
         nib_cnt   <= '0;
         coeff_cnt <= '0;
         pack      <= '0;
         s_we      <= 1'b0;
         s_addr    <= '0;
         s_din     <= '0;
         done      <= 1'b0;
      end else begin
         s_we <= 1'b0;
         done <= (state == ST_FIN);
         case (state)
            ST_IDLE: if (go) begin
               kl_q     <= cfg.k + cfg.l;
               eta4_q   <= cfg.eta4;
               poly_idx <= '0;
            end
            ST_CLR: begin
               abs_cnt   <= '0;
               nib_buf   <= '0;
               nib_cnt   <= '0;
               coeff_cnt <= '0;
               pack      <= '0;
            end
            ST_ABSORB: if (in_fire) abs_cnt <= abs_cnt + 1'b1;
            ST_SQUEEZE: begin
               if (out_fire) begin
                  nib_buf <= sh_out_data;
                  nib_cnt <= NIB_CW'(NIBS);
               end else if (consume) begin
                  nib_buf <= nib_buf >> 4;
                  nib_cnt <= nib_cnt - 1'b1;
                  if (accept) begin
                     pack[slot] <= dec_coeff;
                     coeff_cnt  <= coeff_cnt + 8'd1;
                     if (slot == SLOT_W'(COEFF_PER_WORD - 1)) begin
                        s_we   <= 1'b1;
                        s_addr <= NTT_ADDR_WIDTH'(S_BASE)
                                + NTT_ADDR_WIDTH'(poly_idx) * NTT_ADDR_WIDTH'(WORDS_PER_POLY)
                                + NTT_ADDR_WIDTH'(coeff_cnt >> SLOT_W);
                        s_din  <= pack_next;
                     end
                     // Polynomial complete: drop whatever nibbles remain buffered.
                     if (coeff_cnt == 8'd255) begin
                        nib_cnt  <= '0;
                        poly_idx <= poly_idx + 4'd1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_expand_s_stream.sv
// Bench for expand_s_stream: a stand-in sponge (keyed mixer over the absorbed
// words), a rho' RAM with one-cycle read latency, a reference model that turns
// the squeeze stream into the expected NTT writes, and an in-order write check.
`timescale 1ns/1ps
module tb_expand_s_stream;

   localparam int          QV    = 8380417;
   localparam int          WW    = 64;
   localparam int          LEN_W = 7;
   localparam int          RBASE = 0;
   localparam int          SBASE = 0;

   logic              clk, rst, start;
   logic [1:0]        mode;
   logic              busy, done, sh_rst, sh_in_valid, sh_in_last, sh_in_ready;
   logic              sh_out_valid, sh_out_ready, s_we;
   logic [11:0]       rho_addr, s_addr;
   logic [WW-1:0]     rho_data, sh_in_data, sh_out_data;
   logic [LEN_W-1:0]  sh_in_last_len;
   logic [95:0]       s_din;

   expand_s_stream dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
      .rho_addr(rho_addr), .rho_data(rho_data), .sh_rst(sh_rst),
      .sh_in_data(sh_in_data), .sh_in_valid(sh_in_valid), .sh_in_last(sh_in_last),
      .sh_in_last_len(sh_in_last_len), .sh_in_ready(sh_in_ready),
      .sh_out_data(sh_out_data), .sh_out_valid(sh_out_valid), .sh_out_ready(sh_out_ready),
      .s_we(s_we), .s_addr(s_addr), .s_din(s_din)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- shared state ----------------
   int           vectors = 0, miscompares = 0;
   int           wr_cnt, done_cnt, rst_cnt, exp_kl;
   logic [63:0]  ram [0:4095];
   logic [107:0] exp_q[$];
   logic [63:0]  nonce_q[$];
   logic [95:0]  img [0:4095];
   logic [95:0]  ref_img [0:959];
   logic [95:0]  first_wr_data;
   logic [11:0]  last_wr_addr;
   bit           throttle, pat_en;
   logic [63:0]  pat_word;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mix64(input logic [63:0] x);
      logic [63:0] z;
      z = x + 64'h9E3779B97F4A7C15;
      z = (z ^ (z >> 30)) * 64'hBF58476D1CE4E5B9;
      z = (z ^ (z >> 27)) * 64'h94D049BB133111EB;
      return z ^ (z >> 31);
   endfunction

   function automatic logic [63:0] sq_word(input logic [63:0] h, input int j);
      if (pat_en) return pat_word;
      return mix64(h + 64'(j));
   endfunction

   // ---------------- rho' RAM, read latency 1 ----------------
   always @(posedge clk) rho_data <= ram[rho_addr];

   // ---------------- stand-in sponge ----------------
   initial begin : fake_shake
      logic             f_rst, f_in, f_out, f_last;
      logic [63:0]      f_w, fs_h;
      logic [LEN_W-1:0] f_len;
      int               fs_nabs, fs_j;
      bit               fs_sq;
      sh_in_ready = 1'b0; sh_out_valid = 1'b0; sh_out_data = '0;
      fs_h = '0; fs_nabs = 0; fs_j = 0; fs_sq = 0;
      forever begin
         @(negedge clk);
         f_rst  = sh_rst || rst;
         f_in   = sh_in_valid && sh_in_ready;
         f_out  = sh_out_valid && sh_out_ready;
         f_last = sh_in_last;
         f_w    = sh_in_data;
         f_len  = sh_in_last_len;
         @(posedge clk); #1;
         if (f_rst) begin
            fs_h = '0; fs_nabs = 0; fs_j = 0; fs_sq = 0;
         end else begin
            if (f_in) begin
               fs_h = mix64(fs_h ^ f_w ^ 64'(fs_nabs));
               fs_nabs++;
               if (f_last) begin
                  fs_sq = 1; fs_j = 0;
                  check("absorb_word_count", fs_nabs, 9);
                  check("last_len", f_len, 16);
                  nonce_q.push_back(f_w);
               end
            end
            if (f_out) fs_j++;
         end
         sh_in_ready  = throttle ? ($urandom_range(0, 9) < 3) : 1'b1;
         sh_out_valid = fs_sq && (throttle ? ($urandom_range(0, 9) < 3) : 1'b1);
         sh_out_data  = sq_word(fs_h, fs_j);
      end
   end

   // ---------------- scoreboard / monitor ----------------
   initial begin : monitor
      logic [107:0] e;
      forever begin
         @(negedge clk);
         if (s_we) begin
            wr_cnt++;
            last_wr_addr = s_addr;
            if (wr_cnt == 1) first_wr_data = s_din;
            img[s_addr] = s_din;
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_write: addr %0d data %0h, none expected", s_addr, s_din);
            end else begin
               e = exp_q.pop_front();
               check("s_write", {s_addr, s_din}, e);
            end
         end
         if (done) begin
            done_cnt++;
            check("done_after_last_write", exp_q.size(), 0);
         end
         if (sh_rst) rst_cnt++;
      end
   end

   // ---------------- reference model ----------------
   task automatic build_expected(input logic [1:0] m);
      int          kl, eta, cnt, j, b, v;
      logic [63:0] h, w;
      logic [95:0] word;
      case (m)
         2'd1:    begin kl = 11; eta = 4; end
         2'd2:    begin kl = 15; eta = 2; end
         default: begin kl = 8;  eta = 2; end
      endcase
      exp_q.delete();
      for (int p = 0; p < kl; p++) begin
         h = '0;
         for (int i = 0; i < 8; i++) h = mix64(h ^ ram[RBASE + i] ^ 64'(i));
         h = mix64(h ^ 64'(p) ^ 64'(8));
         cnt = 0; j = 0; word = '0;
         while (cnt < 256) begin
            w = sq_word(h, j);
            j++;
            for (int n = 0; n < 16 && cnt < 256; n++) begin
               b = int'(w[4*n +: 4]);
               if ((eta == 4) ? (b < 9) : (b < 15)) begin
                  v = (eta == 4) ? (4 - b) : (2 - (b % 5));
                  word[(cnt % 4) * 24 +: 24] = 24'((v < 0) ? (QV + v) : v);
                  cnt++;
                  if (cnt % 4 == 0) begin
                     exp_q.push_back({12'(SBASE + p * 64 + cnt / 4 - 1), word});
                     word = '0;
                  end
               end
            end
         end
      end
      exp_kl = kl;
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input logic [1:0] m);
      @(posedge clk); #1 mode = m; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ctrl"}, {busy, done, sh_rst, sh_in_valid, sh_in_last, sh_out_ready, s_we}, 7'd0);
      check({tag, "_rho_addr"}, rho_addr, 0);
      check({tag, "_sh_in"}, {sh_in_data, sh_in_last_len}, 0);
      check({tag, "_s_bus"}, {s_addr, s_din}, 0);
   endtask

   task automatic run_op(input logic [1:0] m, input bit thr, input bit poke_busy,
                         input bit start_at_done, input int exp_writes);
      int cyc;
      build_expected(m);
      throttle = thr; wr_cnt = 0; done_cnt = 0; rst_cnt = 0;
      nonce_q.delete();
      for (int i = 0; i < 4096; i++) img[i] = '0;
      pulse_start(m);
      @(negedge clk);
      check("busy_after_start", busy, 1);
      if (poke_busy) begin
         repeat (40) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      cyc = 0;
      while (!done && cyc < 15000) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", done, 1);
      if (start_at_done) begin
         start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("write_count", wr_cnt, exp_writes);
      check("done_pulses", done_cnt, 1);
      check("sh_rst_pulses", rst_cnt, exp_kl);
      check("busy_after_done", busy, 0);
      check("exp_queue_drained", exp_q.size(), 0);
   endtask

   task automatic compare_image(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 960; i++) if (img[i] !== ref_img[i]) bad++;
      check(name, bad, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int          cyc;
      logic [63:0] nw;
      rst = 1'b1; start = 1'b0; mode = 2'd0;
      throttle = 0; pat_en = 0; pat_word = '0;
      wr_cnt = 0; done_cnt = 0; rst_cnt = 0; exp_kl = 0;
      first_wr_data = '0; last_wr_addr = '0;
      for (int i = 0; i < 16; i++) ram[i] = mix64(64'(i) ^ 64'h5A5A_0000_1234_0000);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1 rst = 1'b0;

      // eta4, stream 9,F,0,8,0,0,...: 9 and F rejected, then 4, q-4, 4, 4
      pat_en = 1; pat_word = 64'h0000_0000_0000_80F9;
      run_op(2'd1, 0, 0, 0, 704);
      check("eta4_first_word", first_wr_data, {24'd4, 24'd4, 24'd8380413, 24'd4});

      // eta2, all-zero nibbles: every coefficient is 2; nonces 0..7
      pat_word = 64'h0;
      run_op(2'd0, 0, 0, 0, 512);
      check("eta2_zero_first_word", first_wr_data, {24'd2, 24'd2, 24'd2, 24'd2});
      check("nonce_count", nonce_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         nw = (i < nonce_q.size()) ? nonce_q[i] : '1;
         check("nonce_word", nw, 64'(i));
      end

      // eta2, stream 4,F,7,E: q-2, (reject), 0, q-2, then 2
      pat_word = 64'h0000_0000_0000_E7F4;
      run_op(2'd2, 0, 0, 0, 960);
      check("eta2_mix_first_word", first_wr_data, {24'd2, 24'd8380415, 24'd0, 24'd8380415});
      check("mode2_last_addr", last_wr_addr, 959);

      // pseudo-random squeeze stream, unthrottled reference image
      pat_en = 0;
      run_op(2'd2, 0, 0, 0, 960);
      for (int i = 0; i < 960; i++) ref_img[i] = img[i];

      // same run with throttled absorb/squeeze
      run_op(2'd2, 1, 0, 0, 960);
      compare_image("throttled_image");

      // eta4 throttled, with a start pulse while busy
      run_op(2'd1, 1, 1, 0, 704);

      // reserved mode behaves as mode 0; start coinciding with done is ignored
      run_op(2'd3, 0, 0, 1, 512);

      // reset in the middle of polynomial 3
      build_expected(2'd2);
      throttle = 0; wr_cnt = 0; done_cnt = 0; rst_cnt = 0;
      pulse_start(2'd2);
      cyc = 0;
      while (rst_cnt < 4 && cyc < 10000) begin
         @(negedge clk);
         cyc++;
      end
      check("reached_poly3", rst_cnt, 4);
      repeat (60) @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_idle_outputs("mid_reset");
      @(posedge clk); #1 rst = 1'b0;
      repeat (30) @(negedge clk);
      check("no_done_after_abort", done_cnt, 0);
      check("idle_after_abort", busy, 0);

      run_op(2'd2, 0, 0, 0, 960);
      compare_image("rerun_after_reset_image");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
